// File: rtl/trace_addr_sequencer.sv
// rtl/trace_addr_sequencer.sv - fetches 256-bit trace lines from BRAM and serialises them into addr FIFO writes
module trace_addr_sequencer #(
    parameter int BRAM_RD_LATENCY = 2,
    parameter int FIFO_HIGH_WM    = 56
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [31:0]  base_line,
    input  logic [31:0]  num_addrs,
    output logic         bram_rd_en,
    output logic [31:0]  bram_addr,
    input  logic [255:0] bram_data,
    input  logic [15:0]  words_in_fifo,
    output logic [31:0]  fifo_din,
    output logic         fifo_wr,
    output logic         busy,
    output logic         done,
    output logic [31:0]  issued_cnt
);

    localparam int WW = (BRAM_RD_LATENCY > 1) ? $clog2(BRAM_RD_LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t         state;
    logic [31:0]    base_q;
    logic [31:0]    remaining;
    logic [31:0]    line_idx;
    logic [255:0]   line_q;
    logic [2:0]     word_idx;
    logic [WW-1:0]  wait_cnt;
    logic           room_ok;

    // Occupancy may lag our own writes by two cycles; the watermark leaves that headroom.
    assign room_ok  = !(words_in_fifo >= 16'(FIFO_HIGH_WM));
    assign fifo_wr  = (state == S_DRAIN) && !abort && room_ok;
    assign fifo_din = line_q[{word_idx, 5'd0} +: 32];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            base_q     <= '0;
            remaining  <= '0;
            line_idx   <= '0;
            line_q     <= '0;
            word_idx   <= '0;
            wait_cnt   <= '0;
            bram_rd_en <= 1'b0;
            bram_addr  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            issued_cnt <= '0;
        end else begin
            done       <= 1'b0;
            bram_rd_en <= 1'b0;
            if (state != S_IDLE && abort) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            issued_cnt <= '0;
                            base_q     <= base_line;
                            remaining  <= num_addrs;
                            line_idx   <= '0;
                            if (num_addrs == 32'd0) begin
                                state <= S_FIN;
                                done  <= 1'b1;
                            end else begin
                                state      <= S_FETCH;
                                busy       <= 1'b1;
                                bram_rd_en <= 1'b1;
                                bram_addr  <= base_line;
                            end
                        end
                    end
                    S_FETCH: begin
                        wait_cnt <= '0;
                        state    <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (wait_cnt == WW'(BRAM_RD_LATENCY - 1)) begin
                            line_q   <= bram_data;
                            word_idx <= '0;
                            state    <= S_DRAIN;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        if (fifo_wr) begin
                            word_idx   <= word_idx + 3'd1;
                            issued_cnt <= issued_cnt + 32'd1;
                            remaining  <= remaining - 32'd1;
                            if (remaining == 32'd1) begin
                                state <= S_FIN;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else if (word_idx == 3'd7) begin
                                state      <= S_FETCH;
                                line_idx   <= line_idx + 32'd1;
                                bram_rd_en <= 1'b1;
                                bram_addr  <= base_q + line_idx + 32'd1;
                            end
                        end
                    end
                    S_FIN: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trace_addr_sequencer.sv
// tb/tb_trace_addr_sequencer.sv - randomized self-checking bench for trace_addr_sequencer
module tb_trace_addr_sequencer;

    localparam int LAT = 2;
    localparam int WM  = 56;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [31:0]  base_line = '0;
    logic [31:0]  num_addrs = '0;
    logic         bram_rd_en;
    logic [31:0]  bram_addr;
    logic [255:0] bram_data;
    logic [15:0]  words_in_fifo = '0;
    logic [31:0]  fifo_din;
    logic         fifo_wr;
    logic         busy;
    logic         done;
    logic [31:0]  issued_cnt;

    trace_addr_sequencer #(.BRAM_RD_LATENCY(LAT), .FIFO_HIGH_WM(WM)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .base_line(base_line), .num_addrs(num_addrs),
        .bram_rd_en(bram_rd_en), .bram_addr(bram_addr), .bram_data(bram_data),
        .words_in_fifo(words_in_fifo), .fifo_din(fifo_din), .fifo_wr(fifo_wr),
        .busy(busy), .done(done), .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [31:0] seed;

    logic [31:0] exp_q[$];
    logic [31:0] exp_lines[$];
    int wr_cnt, done_cnt, done_cyc, first_wr, first_rd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] line, input int k);
        return (line * 32'h9E3779B9) ^ (32'(k) * 32'h85EBCA6B) ^ seed;
    endfunction

    // BRAM model: data is valid exactly LAT cycles after the read strobe, garbage otherwise
    logic         rd_v [LAT] = '{default: 1'b0};
    logic [31:0]  rd_a [LAT] = '{default: 32'd0};
    logic [255:0] garbage = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rd_v[0] <= bram_rd_en;
        rd_a[0] <= bram_addr;
        for (int i = 1; i < LAT; i++) begin
            rd_v[i] <= rd_v[i-1];
            rd_a[i] <= rd_a[i-1];
        end
        for (int k = 0; k < 8; k++) garbage[32*k +: 32] <= $urandom;
    end

    always @* begin
        for (int k = 0; k < 8; k++)
            bram_data[32*k +: 32] = rd_v[LAT-1] ? word_of(rd_a[LAT-1], k) : garbage[32*k +: 32];
    end

    always @(negedge clk) begin
        if (fifo_wr) begin
            wr_cnt++;
            if (first_wr < 0) first_wr = cyc;
            if (exp_q.size() == 0) check("extra_wr", 1, 0);
            else check("fifo_din", fifo_din, exp_q.pop_front());
        end
        if (bram_rd_en) begin
            if (first_rd < 0) first_rd = cyc;
            if (exp_lines.size() == 0) check("extra_rd", 1, 0);
            else check("bram_addr", bram_addr, exp_lines.pop_front());
        end
        if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        if (busy && words_in_fifo >= 16'(WM)) check("throttle", fifo_wr, 0);
    end

    task automatic prep(input logic [31:0] base, input logic [31:0] n);
        exp_q.delete();
        exp_lines.delete();
        for (int i = 0; i < int'(n); i++) exp_q.push_back(word_of(base + 32'(i / 8), i % 8));
        for (int l = 0; l < (int'(n) + 7) / 8; l++) exp_lines.push_back(base + 32'(l));
        wr_cnt = 0; done_cnt = 0; done_cyc = -1; first_wr = -1; first_rd = -1;
    endtask

    task automatic run_seq(input logic [31:0] base, input logic [31:0] n, input bit thr,
                           input int abort_at, input bit timed);
        int s_cyc;
        bit finished;
        bit aborted;
        int nl;
        prep(base, n);
        finished = 0;
        aborted = 0;
        nl = (int'(n) + 7) / 8;
        @(posedge clk); #1;
        start = 1; abort = ($urandom_range(0, 1) == 1); base_line = base; num_addrs = n;
        s_cyc = cyc;
        @(posedge clk); #1;
        start = 0; abort = 0; base_line = $urandom; num_addrs = $urandom;
        for (int j = 0; j < 3000 && !finished; j++) begin
            @(posedge clk); #1;
            start = 0;
            abort = 0;
            if (aborted) begin
                check("abort_busy", busy, 0);
                finished = 1;
            end else if (done_cnt > 0) begin
                finished = 1;
            end else begin
                if (thr) words_in_fifo = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(WM, WM + 20))
                                                                   : 16'($urandom_range(0, WM - 1));
                if (j == 1 && n != 0) start = 1;
                if (abort_at >= 0 && wr_cnt == abort_at) begin
                    abort = 1;
                    aborted = 1;
                end
            end
        end
        if (!finished) check("timeout", 1, 0);
        words_in_fifo = '0;
        repeat (3) @(posedge clk);
        #1;
        if (aborted) begin
            check("abort_no_done", done_cnt, 0);
            check("abort_issued", issued_cnt, abort_at);
        end else begin
            check("done_count", done_cnt, 1);
            check("words_left", exp_q.size(), 0);
            check("lines_left", exp_lines.size(), 0);
            check("issued_cnt", issued_cnt, n);
            check("busy_idle", busy, 0);
            if (timed && !thr) begin
                check("done_lat", done_cyc - s_cyc, nl * (1 + LAT) + int'(n) + 1);
                if (n != 0) begin
                    check("rd_lat", first_rd - s_cyc, 1);
                    check("wr_lat", first_wr - s_cyc, 2 + LAT);
                end
            end
        end
    endtask

    initial begin
        seed = $urandom;
        prep(0, 0);
        repeat (3) @(negedge clk);
        check("rst_rd_en", bram_rd_en, 0);
        check("rst_addr", bram_addr, 0);
        check("rst_wr", fifo_wr, 0);
        check("rst_din", fifo_din, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_issued", issued_cnt, 0);
        @(posedge clk); #1;
        reset = 1;

        run_seq(32'h10, 3, 0, -1, 1);
        run_seq(32'h10, 20, 0, -1, 1);
        run_seq(32'h55, 0, 0, -1, 1);
        run_seq(32'h100, 16, 0, 5, 0);
        run_seq(32'h200, 16, 0, -1, 1);
        run_seq(32'h300, 30, 1, -1, 0);
        run_seq(32'hFFFF_FFFE, 24, 0, -1, 1);

        prep(32'h40, 20);
        @(posedge clk); #1;
        start = 1; base_line = 32'h40; num_addrs = 20;
        @(posedge clk); #1;
        start = 0;
        for (int j = 0; j < 100 && wr_cnt < 3; j++) @(posedge clk);
        check("mid_reached", wr_cnt >= 3, 1);
        @(negedge clk); #2;
        reset = 0;
        #1;
        check("mid_rst_rd_en", bram_rd_en, 0);
        check("mid_rst_addr", bram_addr, 0);
        check("mid_rst_wr", fifo_wr, 0);
        check("mid_rst_din", fifo_din, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_issued", issued_cnt, 0);
        @(posedge clk); #1;
        reset = 1;
        run_seq(32'h40, 11, 0, -1, 1);

        for (int t = 0; t < 25; t++) begin
            logic [31:0] b;
            logic [31:0] n;
            int ab;
            b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : $urandom;
            n = 32'($urandom_range(0, 40));
            ab = ($urandom_range(0, 4) == 0 && n > 2) ? $urandom_range(1, int'(n) - 1) : -1;
            run_seq(b, n, $urandom_range(0, 1) == 1, ab, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
